// File: rtl/pipe_pkg.sv
// Shared state encodings and defaults for the pipeline stage slice.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL  = 2'b01,
      ST_SKID  = 2'b10
   } pipe_state_e;

   localparam int unsigned STALL_W_DEFAULT = 16;

   function automatic logic holds_beat(input pipe_state_e st);
      return (st != ST_EMPTY);
   endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating counter of backpressured cycles; clear beats increment.
module pipe_stall_counter
   import pipe_pkg::*;
#(
   parameter int unsigned STALL_W = STALL_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               inc,
   input  logic               clr,
   output logic [STALL_W-1:0] cnt
);

   logic [STALL_W-1:0] cnt_q;
   logic [STALL_W-1:0] cnt_d;
   logic [STALL_W-1:0] one_s;

   assign one_s = {{(STALL_W-1){1'b0}}, 1'b1};

   // Next count: clear has priority, increment stops at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {STALL_W{1'b0}};
      end else if (inc && (cnt_q != {STALL_W{1'b1}})) begin
         cnt_d = cnt_q + one_s;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= {STALL_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with optional skid entry, flush and a
// saturating stall counter.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SKID    = 1,
   parameter int unsigned STALL_W = STALL_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   input  logic               flush,
   input  logic               stall_clr,
   output logic [STALL_W-1:0] stall_cnt
);

   pipe_state_e      state_q;
   pipe_state_e      state_d;
   pipe_state_e      state_nxt_s;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] main_d;
   logic [WIDTH-1:0] skid_q;
   logic [WIDTH-1:0] skid_d;
   logic             in_xfer_s;
   logic             out_xfer_s;
   logic             stall_inc_s;

   assign out_valid   = holds_beat(state_q);
   assign out_data    = main_q;
   assign in_xfer_s   = in_valid & in_ready;
   assign out_xfer_s  = out_valid & out_ready;
   assign stall_inc_s = out_valid & ~out_ready;

   // Ready is gated by reset so nothing is accepted while the stage is held.
   generate
      if (SKID != 0) begin : g_skid_rdy
         assign in_ready = reset_n & (state_q != ST_SKID);
      end else begin : g_pass_rdy
         assign in_ready = reset_n & ((state_q == ST_EMPTY) | out_ready);
      end
   endgenerate

   // State and payload next values; flush overrides only the state.
   always_comb begin
      state_nxt_s = state_q;
      main_d      = main_q;
      skid_d      = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer_s) begin
               state_nxt_s = ST_FULL;
               main_d      = in_data;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (in_xfer_s && out_xfer_s) begin
               state_nxt_s = ST_FULL;
               main_d      = in_data;
            end else if (in_xfer_s) begin
               // Without a skid entry in_ready implies out_ready, so this is SKID-only.
               if (SKID != 0) begin
                  state_nxt_s = ST_SKID;
                  skid_d      = in_data;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end else if (out_xfer_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         ST_SKID: begin
            if (out_xfer_s) begin
               state_nxt_s = ST_FULL;
               main_d      = skid_q;
            end else begin
               state_nxt_s = ST_SKID;
            end
         end
         default: begin
            state_nxt_s = ST_EMPTY;
         end
      endcase
      state_d = flush ? ST_EMPTY : state_nxt_s;
   end

   // Stage registers; reset clears both payload entries.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_EMPTY;
         main_q  <= {WIDTH{1'b0}};
         skid_q  <= {WIDTH{1'b0}};
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   pipe_stall_counter #(
      .STALL_W (STALL_W)
   ) u_stall (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (stall_inc_s),
      .clr     (stall_clr),
      .cnt     (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three configurations against a queue model,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_skid;

   localparam int N = 3;

   logic        clk;
   logic        reset_n;
   logic        in_valid  [N];
   logic        in_ready  [N];
   logic [31:0] in_data   [N];
   logic        out_valid [N];
   logic        out_ready [N];
   logic [31:0] out_data  [N];
   logic        flush     [N];
   logic        stall_clr [N];
   logic [31:0] sc_w      [N];
   logic [15:0] sc0;
   logic [15:0] sc1;
   logic [1:0]  sc2;

   int checks = 0;
   int errors = 0;

   // model state: occupancy, held beats, stall count, payload-is-zero flag
   int          mcnt  [N];
   logic [31:0] mfifo [N][2];
   int          msc   [N];
   bit          mzero [N];
   bit          mknown;

   pipe_stage_skid #(.WIDTH(32), .SKID(1), .STALL_W(16)) u_s1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .flush(flush[0]), .stall_clr(stall_clr[0]), .stall_cnt(sc0));

   pipe_stage_skid #(.WIDTH(32), .SKID(0), .STALL_W(16)) u_s0 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .flush(flush[1]), .stall_clr(stall_clr[1]), .stall_cnt(sc1));

   pipe_stage_skid #(.WIDTH(32), .SKID(1), .STALL_W(2)) u_sw2 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_data(out_data[2]), .flush(flush[2]), .stall_clr(stall_clr[2]), .stall_cnt(sc2));

   assign sc_w[0] = {16'h0000, sc0};
   assign sc_w[1] = {16'h0000, sc1};
   assign sc_w[2] = {30'h0, sc2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int skid_of(input int i);
      return (i == 1) ? 0 : 1;
   endfunction

   function automatic int sat_of(input int i);
      return (i == 2) ? 3 : 65535;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Compare process: check outputs late in each cycle, then advance the model.
   initial begin : compare
      mknown = 1'b0;
      for (int i = 0; i < N; i++) begin
         mcnt[i]  = 0;
         msc[i]   = 0;
         mzero[i] = 1'b1;
      end
      forever begin
         @(negedge clk);
         #4;
         for (int i = 0; i < N; i++) begin
            bit ev;
            bit er;
            bit ix;
            bit ox;
            ev = (mcnt[i] > 0);
            er = reset_n && ((skid_of(i) != 0) ? (mcnt[i] < 2)
                                               : ((mcnt[i] == 0) || out_ready[i]));
            chk($sformatf("u%0d.in_ready", i), {31'd0, in_ready[i]}, {31'd0, er});
            if (mknown) begin
               chk($sformatf("u%0d.out_valid", i), {31'd0, out_valid[i]}, {31'd0, ev});
               if (ev) chk($sformatf("u%0d.out_data", i), out_data[i], mfifo[i][0]);
               else if (mzero[i]) chk($sformatf("u%0d.out_data_zero", i), out_data[i], 32'h0);
               chk($sformatf("u%0d.stall_cnt", i), sc_w[i], msc[i]);
            end
            if (!reset_n) begin
               mcnt[i]  = 0;
               msc[i]   = 0;
               mzero[i] = 1'b1;
            end else begin
               ix = in_valid[i] && er;
               ox = ev && out_ready[i];
               if (stall_clr[i]) msc[i] = 0;
               else if (ev && !out_ready[i] && (msc[i] < sat_of(i))) msc[i] = msc[i] + 1;
               if (flush[i]) begin
                  mcnt[i]  = 0;
                  mzero[i] = 1'b0;
               end else begin
                  if (ox) begin
                     mfifo[i][0] = mfifo[i][1];
                     mcnt[i]     = mcnt[i] - 1;
                  end
                  if (ix) begin
                     mfifo[i][mcnt[i]] = in_data[i];
                     mcnt[i]           = mcnt[i] + 1;
                     mzero[i]          = 1'b0;
                  end
               end
            end
         end
         if (!reset_n) mknown = 1'b1;
      end
   end

   // Stimulus: directed scenarios, then randomized traffic.
   initial begin : stim
      int unsigned seq;
      seq     = 32'h100;
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         in_valid[i]  = 1'b0;
         in_data[i]   = 32'h0;
         out_ready[i] = 1'b0;
         flush[i]     = 1'b0;
         stall_clr[i] = 1'b0;
      end
      repeat (3) tick();
      chk("rst_in_ready_low", {31'd0, in_ready[0]}, 32'h0);
      reset_n = 1'b1;
      #1;
      for (int i = 0; i < N; i++) chk("rel_in_ready", {31'd0, in_ready[i]}, 32'h1);
      chk("rel_out_valid", {31'd0, out_valid[0]}, 32'h0);

      // streaming 1..8 with out_ready high: one cycle latency, no gaps
      out_ready[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = k;
         tick();
         chk("stream_valid", {31'd0, out_valid[0]}, 32'h1);
         chk("stream_data", out_data[0], k);
      end
      in_valid[0] = 1'b0;
      tick();
      chk("stream_drained", {31'd0, out_valid[0]}, 32'h0);

      // fill main and skid under backpressure, then drain in order
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      in_data[0]   = 32'hA;
      tick();
      in_data[0] = 32'hB;
      tick();
      chk("skid_in_ready", {31'd0, in_ready[0]}, 32'h0);
      chk("skid_head", out_data[0], 32'hA);
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b1;
      tick();
      chk("skid_second", out_data[0], 32'hB);
      tick();
      chk("skid_empty", {31'd0, out_valid[0]}, 32'h0);

      // flush from SKID with 0xC presented
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      in_data[0]   = 32'h1;
      tick();
      in_data[0] = 32'h2;
      tick();
      flush[0]   = 1'b1;
      in_data[0] = 32'hC;
      tick();
      flush[0]    = 1'b0;
      in_valid[0] = 1'b0;
      chk("flush_skid_valid", {31'd0, out_valid[0]}, 32'h0);
      out_ready[0] = 1'b1;
      repeat (3) begin
         tick();
         chk("flush_no_c", {31'd0, out_valid[0]}, 32'h0);
      end
      // flush from FULL while a beat is accepted: the beat is dropped
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      in_data[0]   = 32'h3;
      tick();
      flush[0]   = 1'b1;
      in_data[0] = 32'hC5;
      tick();
      flush[0]    = 1'b0;
      in_valid[0] = 1'b0;
      chk("flush_full_valid", {31'd0, out_valid[0]}, 32'h0);
      tick();
      chk("flush_full_stay", {31'd0, out_valid[0]}, 32'h0);

      // 2-bit stall counter saturates, clear wins, flush leaves it alone
      out_ready[2] = 1'b0;
      in_valid[2]  = 1'b1;
      in_data[2]   = 32'h5;
      tick();
      in_valid[2] = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         tick();
         chk("stall_sat", sc_w[2], (j > 3) ? 3 : j);
      end
      stall_clr[2] = 1'b1;
      tick();
      chk("stall_clr", sc_w[2], 32'h0);
      stall_clr[2] = 1'b0;
      tick();
      chk("stall_resume", sc_w[2], 32'h1);
      flush[2] = 1'b1;
      tick();
      flush[2] = 1'b0;
      chk("stall_flush", sc_w[2], 32'h2);
      chk("stall_flush_valid", {31'd0, out_valid[2]}, 32'h0);
      tick();
      chk("stall_hold", sc_w[2], 32'h2);

      // pass-through ready follows out_ready in the same cycle
      in_valid[1]  = 1'b1;
      in_data[1]   = 32'h11;
      out_ready[1] = 1'b1;
      tick();
      out_ready[1] = 1'b0;
      in_data[1]   = 32'h22;
      #1;
      chk("pt_ready_lo", {31'd0, in_ready[1]}, 32'h0);
      tick();
      chk("pt_hold", out_data[1], 32'h11);
      out_ready[1] = 1'b1;
      #1;
      chk("pt_ready_hi", {31'd0, in_ready[1]}, 32'h1);
      tick();
      chk("pt_next", out_data[1], 32'h22);
      in_data[1] = 32'h33;
      tick();
      chk("pt_stream", out_data[1], 32'h33);
      in_valid[1] = 1'b0;
      tick();
      chk("pt_empty", {31'd0, out_valid[1]}, 32'h0);

      // reset while FULL holds 0xDEAD
      out_ready[0] = 1'b0;
      in_valid[0]  = 1'b1;
      in_data[0]   = 32'hDEAD;
      tick();
      chk("rst_full_data", out_data[0], 32'hDEAD);
      in_valid[0] = 1'b0;
      reset_n     = 1'b0;
      #1;
      chk("rst_ready_low", {31'd0, in_ready[0]}, 32'h0);
      tick();
      chk("rst_valid", {31'd0, out_valid[0]}, 32'h0);
      chk("rst_data", out_data[0], 32'h0);
      chk("rst_stall", sc_w[0], 32'h0);
      reset_n = 1'b1;
      #1;
      chk("rst_release_ready", {31'd0, in_ready[0]}, 32'h1);

      // randomized traffic with unique payloads
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            in_valid[i]  = ($urandom_range(0, 3) != 0);
            out_ready[i] = ($urandom_range(0, 2) != 0);
            flush[i]     = ($urandom_range(0, 31) == 0);
            stall_clr[i] = ($urandom_range(0, 15) == 0);
            in_data[i]   = seq;
            seq          = seq + 1;
         end
         reset_n = ($urandom_range(0, 499) != 0);
         tick();
      end

      reset_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         in_valid[i]  = 1'b0;
         out_ready[i] = 1'b1;
         flush[i]     = 1'b0;
         stall_clr[i] = 1'b0;
      end
      repeat (5) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..1024).
REQ-002 Parameter SKID, default 1: 1 adds a skid entry with registered in_ready; 0 gives a single entry with pass-through in_ready.
REQ-003 Parameter STALL_W, default 16, width of the stall-cycle counter (2..32).
REQ-004 Port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 Port reset_n, input, 1, synchronous active-low reset.
REQ-006 Port in_valid, input, 1, upstream beat present.
REQ-007 Port in_ready, output, 1, stage can accept a beat this cycle.
REQ-008 Port in_data, input, WIDTH, upstream payload.
REQ-009 Port out_valid, output, 1, stage holds a beat for downstream.
REQ-010 Port out_ready, input, 1, downstream accepts this cycle.
REQ-011 Port out_data, output, WIDTH, head payload.
REQ-012 Port flush, input, 1, discard all held beats (branch or jump squash).
REQ-013 Port stall_clr, input, 1, clear the stall counter.
REQ-014 Port stall_cnt, output, STALL_W, saturating count of backpressured cycles.

Function
REQ-015 Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-016 Beats emerge in acceptance order, with no loss or duplication except by flush.
REQ-017 Latency from input transfer to out_valid SHALL be 1 cycle when the stage is empty.
REQ-018 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-019 States SHALL be EMPTY (no beat), FULL (main entry valid) and SKID (main and skid entries valid); SKID is reachable only when SKID=1.
REQ-020 out_valid = (state != EMPTY); out_data = main entry.
REQ-021 EMPTY: on input transfer, go to FULL and load main from in_data.
REQ-022 FULL: input and output transfer together -> stay in FULL, main loads in_data.
REQ-023 FULL: input transfer with no output transfer -> go to SKID and load skid from in_data (SKID=1 only).
REQ-024 FULL: output transfer only -> go to EMPTY.
REQ-025 SKID: on output transfer, go to FULL and load main from the skid entry.
REQ-026 SKID=1: in_ready = (state != SKID), decoded from flops only, with no combinational path from out_ready.
REQ-027 SKID=0: in_ready = (state == EMPTY) | out_ready, so full throughput is kept under a combinational ready path.
REQ-028 Flush: the next state is EMPTY regardless of other inputs; an input beat accepted in the same cycle is dropped; payload registers may keep stale data.
REQ-029 Flush SHALL NOT alter stall_cnt.
REQ-030 stall_cnt increments on each cycle with out_valid=1 and out_ready=0, and holds at all-ones (saturates).
REQ-031 stall_clr sets stall_cnt to 0 on the next edge; when stall_clr coincides with an increment condition, clear wins.
REQ-032 Sustained in_valid=1 and out_ready=1 SHALL give one beat per cycle for both SKID values.

Reset
REQ-033 While reset_n=0 at an edge, the next state is EMPTY, main and skid payloads become 0, and stall_cnt becomes 0.
REQ-034 in_ready SHALL be 0 while reset_n=0, and 1 in the first cycle after release.
REQ-035 Reset asserted mid-transfer discards all held beats, with no partial output.
REQ-036 Reset has priority over flush, stall_clr and all transfers.

Structure
REQ-037 Package pipe_pkg holds the state encodings EMPTY/FULL/SKID (2-bit) and the default STALL_W.
REQ-038 The stall counter is a sub-module pipe_stall_counter with parameter STALL_W and ports clk, reset_n, inc, clr, cnt.
REQ-039 The payload datapath has no reset dependency beyond REQ-033, and no latches.

Verification
REQ-040 SKID=1, WIDTH=32, out_ready=1; inject 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later, with no gaps.
REQ-041 SKID=1; out_ready=0, then inject 0xA and 0xB -> state SKID and in_ready=0; raise out_ready -> 0xA then 0xB on consecutive cycles.
REQ-042 Stage in SKID state; assert flush while also presenting 0xC -> next cycle out_valid=0, and 0xC never emerges.
REQ-043 STALL_W=2; hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt 1,2,3,3,3; stall_clr with the stall still active -> 0.
REQ-044 SKID=0; out_ready toggling 1,0,1 with continuous input -> in_ready tracks out_ready same-cycle, and order is preserved.
REQ-045 Drop reset_n while FULL holds 0xDEAD -> next cycle out_valid=0, out_data=0, stall_cnt=0; in_ready=1 after release.
